// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: register offsets, CTRL bit positions, default base and byte-lane merge
package mmio_timer_pkg;
  typedef enum logic [1:0] {
    TIMER_CTRL  = 2'd0,
    TIMER_COUNT = 2'd1,
    TIMER_CMP   = 2'd2,
    TIMER_STAT  = 2'd3
  } timer_reg_e;
  localparam int CTRL_EN = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam logic [31:0] TIMER_BASE_DEFAULT = 32'h1000_0000;
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: CPU data-memory bus between master and the timer responder
interface mmio_timer_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  modport master (output ce, we, addr, sel, data_i, input data_o);
  modport slave (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// timer_prescaler: divides clk by divisor+1 while enabled, emitting one-cycle ticks
module timer_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] divisor,
  input  logic         clear,
  output logic         tick
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = en && cnt_q == divisor;
    cnt_d = (clear || !en || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled up-counter with compare, sticky match and level irq
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE_DEFAULT,
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  mmio_timer_if.slave bus,
  output logic        irq_o
);
  localparam logic [31:0] CTRL_MASK = 32'h7 | (((32'd1 << PRESCALE_W) - 32'd1) << CTRL_PRESCALE_LSB);
  // byte lanes that carry any PRESCALE bit; touching them restarts the prescaler
  localparam logic [3:0] PS_LANES = 4'(((1 << ((PRESCALE_W + 7) / 8)) - 1) << 1);
  logic [31:0] ctrl_q, ctrl_d, count_q, count_d, cmp_q, cmp_d;
  logic match_q, match_d, match_set;
  logic hit, wr_ctrl, wr_count, wr_cmp, wr_stat, tick, ps_clear, unused_addr;
  timer_reg_e off;
  always_comb begin
    off = timer_reg_e'(bus.addr[3:2]);
    hit = bus.ce && bus.addr[31:4] == BASE_ADDR[31:4];
    wr_ctrl = hit && bus.we && off == TIMER_CTRL;
    wr_count = hit && bus.we && off == TIMER_COUNT;
    wr_cmp = hit && bus.we && off == TIMER_CMP;
    wr_stat = hit && bus.we && off == TIMER_STAT;
    unused_addr = ^bus.addr[1:0];
    ps_clear = wr_ctrl && ((|(bus.sel & PS_LANES)) || (bus.sel[0] && !bus.data_i[CTRL_EN]));
    ctrl_d = wr_ctrl ? merge_lanes(ctrl_q, bus.data_i, bus.sel) & CTRL_MASK : ctrl_q;
    cmp_d = wr_cmp ? merge_lanes(cmp_q, bus.data_i, bus.sel) : cmp_q;
    match_set = tick && !wr_count && count_q == cmp_q;
    count_d = wr_count ? merge_lanes(count_q, bus.data_i, bus.sel) :
              !tick ? count_q :
              (match_set && ctrl_q[CTRL_AUTO_RELOAD]) ? '0 : count_q + 32'd1;
    // a new match outranks a same-cycle clear
    match_d = match_set || (match_q && !(wr_stat && bus.sel[0] && bus.data_i[0]));
    bus.data_o = !(hit && !bus.we) ? '0 :
                 off == TIMER_CTRL ? ctrl_q :
                 off == TIMER_COUNT ? count_q :
                 off == TIMER_CMP ? cmp_q : {31'b0, match_q};
    irq_o = match_q && ctrl_q[CTRL_IRQ_EN];
  end
  timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk(clk),
    .rst(rst),
    .en(ctrl_q[CTRL_EN]),
    .divisor(ctrl_q[CTRL_PRESCALE_LSB +: PRESCALE_W]),
    .clear(ps_clear),
    .tick(tick)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      count_q <= '0;
      cmp_q <= '0;
      match_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      count_q <= count_d;
      cmp_q <= cmp_d;
      match_q <= match_d;
    end
  end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed and randomized checks of mmio_timer against a behavioural model
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'h1000_0000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_ctrl, m_count, m_cmp;
  logic m_match;
  int m_run;
  mmio_timer_if bus();
  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (.clk(clk), .rst(rst), .bus(bus), .irq_o(irq));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic logic [31:0] A(input int off);
    return BASE + 32'(off * 4);
  endfunction
  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction
  function automatic logic [31:0] mreg(input logic [1:0] off);
    case (off)
      2'd0: return m_ctrl;
      2'd1: return m_count;
      2'd2: return m_cmp;
      default: return {31'b0, m_match};
    endcase
  endfunction
  function automatic logic m_irq();
    return m_match && m_ctrl[2];
  endfunction
  task automatic model_reset();
    m_ctrl = 0; m_count = 0; m_cmp = 0; m_match = 0; m_run = 0;
  endtask
  // advance one clock: the model consumes whatever is on the bus now
  task automatic step();
    logic hit, wr, tick, mset, clr, restart;
    logic [1:0] off;
    logic [31:0] nc, ncount, ncmp;
    int ps;
    hit = bus.ce && bus.addr[31:4] == BASE[31:4];
    wr = hit && bus.we;
    off = bus.addr[3:2];
    ps = int'(m_ctrl[15:8]);
    tick = m_ctrl[0] && (m_run % (ps + 1)) == ps;
    mset = 0;
    nc = m_ctrl; ncount = m_count; ncmp = m_cmp;
    if (wr && off == 2'd0) nc = lanes(m_ctrl, bus.data_i, bus.sel) & 32'h0000_FF07;
    if (wr && off == 2'd2) ncmp = lanes(m_cmp, bus.data_i, bus.sel);
    if (wr && off == 2'd1) ncount = lanes(m_count, bus.data_i, bus.sel);
    else if (tick) begin
      mset = m_count == m_cmp;
      ncount = (mset && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
    end
    clr = wr && off == 2'd3 && bus.sel[0] && bus.data_i[0];
    restart = !m_ctrl[0] || (wr && off == 2'd0 && (bus.sel[1] || (bus.sel[0] && !bus.data_i[0])));
    @(posedge clk);
    m_ctrl = nc; m_count = ncount; m_cmp = ncmp;
    m_match = (m_match && !clr) || mset;
    m_run = restart ? 0 : m_run + 1;
    #1;
  endtask
  task automatic idle();
    bus.ce = 0; bus.we = 0;
    step();
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.ce = 1; bus.we = 0; bus.addr = a; bus.sel = 4'($urandom); bus.data_i = $urandom;
    #1;
    v = bus.data_o;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.ce = 1; bus.we = 1; bus.addr = a; bus.sel = s; bus.data_i = d;
    step();
    bus.ce = 0; bus.we = 0;
  endtask
  task automatic test_reset();
    logic [31:0] v;
    model_reset();
    bus.ce = 0; bus.we = 0; bus.addr = 0; bus.sel = 0; bus.data_i = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rd(A(i), v);
      n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_read%0d: got %h expected 0", i, v); end
    end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rst = 1;
    rd(BASE + 32'h10, v);
    n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL outside_read: got %h expected 0", v); end
    step();
  endtask
  task automatic test_compare_irq();
    logic [31:0] v;
    wr(A(2), 32'd3, 4'hF);
    wr(A(0), 32'h0000_0005, 4'hF);
    for (int i = 0; i < 5; i++) begin
      rd(A(1), v);
      n_chk++; if (v !== 32'(i)) begin n_fail++; $display("FAIL cmp_count%0d: got %h expected %h", i, v, i); end
      n_chk++; if (irq !== (i >= 4)) begin n_fail++; $display("FAIL cmp_irq%0d: got %b expected %b", i, irq, i >= 4); end
      step();
    end
    rd(A(3), v);
    n_chk++; if (v !== 32'd1) begin n_fail++; $display("FAIL cmp_status: got %h expected 1", v); end
    step();
    wr(A(0), 32'd0, 4'hF);
    wr(A(3), 32'd1, 4'h1);
  endtask
  task automatic test_autoreload();
    logic [31:0] v;
    wr(A(1), 32'd0, 4'hF);
    wr(A(2), 32'd2, 4'hF);
    wr(A(0), 32'h0000_0403, 4'hF);
    for (int k = 0; k < 30; k++) begin
      rd(A(1), v);
      n_chk++; if (v !== 32'((k / 5) % 3)) begin n_fail++; $display("FAIL reload_count%0d: got %h expected %h", k, v, (k / 5) % 3); end
      n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reload_irq%0d: got %b expected 0", k, irq); end
      step();
    end
    rd(A(3), v);
    n_chk++; if (v !== 32'd1) begin n_fail++; $display("FAIL reload_status: got %h expected 1", v); end
    step();
    wr(A(0), 32'd0, 4'hF);
    wr(A(3), 32'd1, 4'h1);
  endtask
  task automatic test_byte_lanes();
    logic [31:0] v;
    wr(A(1), 32'hAABB_CCDD, 4'hF);
    wr(A(1), 32'h1122_3344, 4'b0101);
    rd(A(1), v);
    n_chk++; if (v !== 32'hAA22_CC44) begin n_fail++; $display("FAIL lanes_count: got %h expected aa22cc44", v); end
    step();
    wr(A(0), 32'hFFFF_FFFF, 4'hF);
    rd(A(0), v);
    n_chk++; if (v !== 32'h0000_FF07) begin n_fail++; $display("FAIL lanes_ctrl_mask: got %h expected 0000ff07", v); end
    step();
    wr(A(0), 32'd0, 4'hF);
    wr(A(3), 32'd1, 4'h1);
  endtask
  task automatic test_wrap_and_races();
    logic [31:0] v;
    wr(A(2), 32'd5, 4'hF);
    wr(A(1), 32'hFFFF_FFFF, 4'hF);
    wr(A(0), 32'h0000_0005, 4'hF);
    rd(A(1), v);
    n_chk++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_pre: got %h expected ffffffff", v); end
    step();
    rd(A(1), v);
    n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL wrap_count: got %h expected 0", v); end
    rd(A(3), v);
    n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL wrap_match: got %h expected 0", v); end
    step();
    for (int g = 0; g < 20 && m_count != 32'd5; g++) idle();
    n_chk++; if (m_count !== 32'd5) begin n_fail++; $display("FAIL race_timeout: got %h expected 5", m_count); end
    wr(A(3), 32'd1, 4'h1);
    rd(A(3), v);
    n_chk++; if (v !== 32'd1) begin n_fail++; $display("FAIL set_wins: got %h expected 1", v); end
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq: got %b expected 1", irq); end
    step();
    wr(A(3), 32'd1, 4'h1);
    rd(A(3), v);
    n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL w1c: got %h expected 0", v); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b expected 0", irq); end
    step();
    wr(A(1), 32'd100, 4'hF);
    rd(A(1), v);
    n_chk++; if (v !== 32'd100) begin n_fail++; $display("FAIL write_wins: got %h expected 100", v); end
    step();
    wr(A(1), 32'd200, 4'hF);
    wr(A(2), 32'd200, 4'hF);
    rd(A(3), v);
    n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL old_compare: got %h expected 0", v); end
    rd(A(1), v);
    n_chk++; if (v !== 32'd201) begin n_fail++; $display("FAIL old_compare_count: got %h expected 201", v); end
    step();
    wr(A(0), 32'd0, 4'hF);
    wr(A(3), 32'd1, 4'h1);
  endtask
  task automatic test_mid_reset();
    logic [31:0] v;
    wr(A(2), 32'd3, 4'hF);
    wr(A(1), 32'd0, 4'hF);
    wr(A(0), 32'h0000_0005, 4'hF);
    for (int g = 0; g < 30 && m_count != 32'd7; g++) idle();
    rd(A(3), v);
    n_chk++; if (v !== 32'd1 || m_count !== 32'd7) begin n_fail++; $display("FAIL mid_setup: got %h expected 1", v); end
    #1 rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rd(A(i), v);
      n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL mid_reset_read%0d: got %h expected 0", i, v); end
    end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: got %b expected 0", irq); end
    rst = 1;
    repeat (3) idle();
    rd(A(1), v);
    n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL post_reset_count: got %h expected 0", v); end
    rd(A(0), v);
    n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL post_reset_ctrl: got %h expected 0", v); end
    step();
  endtask
  task automatic test_random();
    logic [31:0] v, a, d, e;
    logic [3:0] s;
    int op;
    for (int c = 0; c < 600; c++) begin
      n_chk++; if (irq !== m_irq()) begin n_fail++; $display("FAIL rand_irq%0d: got %b expected %b", c, irq, m_irq()); end
      op = $urandom_range(0, 9);
      a = A($urandom_range(0, 3)) | 32'($urandom_range(0, 3));
      if (op < 4) begin
        e = mreg(a[3:2]);
        rd(a, v);
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL rand_read%0d: got %h expected %h", c, v, e); end
        step();
      end else if (op < 7) begin
        d = $urandom;
        if (a[3:2] == 2'd0) d[15:8] = 8'($urandom_range(0, 3));
        if (a[3:2] == 2'd1 || a[3:2] == 2'd2) d = 32'($urandom_range(0, 12));
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        wr(a, d, s);
      end else if (op == 7) begin
        a = a ^ 32'h0000_0100;
        if ($urandom_range(0, 1) == 0) begin
          rd(a, v);
          n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL rand_miss%0d: got %h expected 0", c, v); end
          step();
        end else wr(a, $urandom, 4'($urandom));
      end else if (op == 8) begin
        bus.ce = 0; bus.we = 1; bus.addr = a; bus.sel = 4'($urandom); bus.data_i = $urandom;
        step();
        bus.we = 0;
      end else idle();
    end
  endtask
  initial begin
    test_reset();
    test_compare_irq();
    test_autoreload();
    test_byte_lanes();
    test_wrap_and_races();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
